// File: rtl/round_key_xor_bank.sv
// Round-key XOR stage: runtime-loaded bank of round keys, XORed onto each word
// through a two-stage elastic valid/ready pipeline.
module round_key_xor_bank #(
    parameter int unsigned DATA_W   = 48,
    parameter int unsigned NUM_KEYS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              key_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_round,
    input  logic              in_decrypt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_round,
    output logic              out_err
);

    localparam int unsigned SLOTS = 1 << IDX_W;

    // One bit per addressable index: set when the index names a real key entry.
    function automatic logic [SLOTS-1:0] range_mask();
        logic [SLOTS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            m[i] = (i < NUM_KEYS);
        end
        return m;
    endfunction

    localparam logic [SLOTS-1:0] RANGE_MASK = range_mask();

    logic [DATA_W-1:0] keys [SLOTS];
    logic [SLOTS-1:0]  loaded;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] s1_key;
    logic [IDX_W-1:0]  s1_round;
    logic              s1_err;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              wr_ok;
    logic              in_range;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_key;
    logic              sel_err;

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
        wr_ok    = key_wr_en && RANGE_MASK[key_wr_idx];
    end

    // Key selection uses the registered bank, so a same-cycle write is not bypassed.
    always_comb begin
        in_range = RANGE_MASK[in_round];
        sel_idx  = in_decrypt ? (IDX_W'(NUM_KEYS - 1) - in_round) : in_round;
        sel_key  = in_range ? keys[sel_idx] : '0;
        sel_err  = !in_range || !loaded[sel_idx];
    end

    // Key bank: clear first, then the write, so a simultaneous write stays loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                keys[i] <= '0;
            end
            loaded <= '0;
        end else begin
            if (key_clear) begin
                loaded <= '0;
            end
            if (wr_ok) begin
                keys[key_wr_idx]   <= key_wr_data;
                loaded[key_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_key   <= '0;
            s1_round <= '0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_key   <= sel_key;
            s1_round <= in_round;
            s1_err   <= sel_err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage holds its payload while stalled downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= s1_data ^ s1_key;
                out_round <= s1_round;
                out_err   <= s1_err;
            end
        end
    end

endmodule

// File: doc/round_key_xor_bank.md
Name: round_key_xor_bank

Overview:
- Parametrised successor to the single-key XOR stage of the Triple-DES datapath.
- Holds a bank of NUM_KEYS round keys, loaded at runtime, and XORs each incoming DATA_W-bit word with the key chosen by round index and direction.
- Two-stage elastic pipeline with valid/ready handshake on both sides.
- Sits between the expansion permutation and the S-box stage of the round engine.

Parameters:
- DATA_W, 48, width of data word and of each round key.
- NUM_KEYS, 16, number of round-key entries (must be >= 2).
- IDX_W, $clog2(NUM_KEYS), round/key index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- key_wr_en  input  1  write key_wr_data into entry key_wr_idx this cycle.
- key_wr_idx  input  IDX_W  key entry to write.
- key_wr_data  input  DATA_W  key value to write.
- key_clear  input  1  invalidate all entries (loaded bits to 0; key values unchanged).
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  DATA_W  expanded data word.
- in_round  input  IDX_W  round number 0..NUM_KEYS-1.
- in_decrypt  input  1  1 = reverse key order.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_W  in_data XOR selected key.
- out_round  output  IDX_W  in_round carried with the result.
- out_err  output  1  selected key not loaded, or round out of range.

Behaviour:
- Reset (async, rst=1): all key registers 0, all loaded bits 0, both stage valids 0. Outputs: out_valid=0, out_data=0, out_round=0, out_err=0, in_ready=1.
- Key index: idx = in_decrypt ? (NUM_KEYS-1-in_round) : in_round.
- Range check: if in_round >= NUM_KEYS, the effective key is 0 and err=1.
- Key write: on key_wr_en, entry[key_wr_idx] <= key_wr_data and loaded[key_wr_idx] <= 1.
  - key_wr_idx >= NUM_KEYS: write ignored.
  - key_clear and key_wr_en in the same cycle: clear is applied, then the write, so the written entry ends loaded=1.
- Stage 1 (S1):
  - Captures in_data, in_round, the selected key value, and err = !loaded[idx] or out-of-range.
  - Transfer happens when in_valid && in_ready.
  - The key is sampled at capture. A write to the same entry in the capture cycle is NOT bypassed: the old value and old loaded bit are used.
- Stage 2 (S2): on S1→S2 advance, out_data <= s1_data ^ s1_key; out_round and out_err follow.
- Handshake:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when s1_valid and S2 can advance.
  - in_ready = !s1_valid || (S2 can advance). This is fully combinational from out_ready; no bubble.
- Latency: 2 cycles from an input handshake to out_valid with no backpressure. Throughput 1 word/cycle.
- Backpressure:
  - With out_ready=0, the pipeline holds up to 2 words; in_ready drops only when both stages are full.
  - Output signals stay stable while out_valid && !out_ready.
- Ordering: words leave strictly in acceptance order. Nothing is dropped or duplicated.
- out_err is informational only: the word still flows, XORed with the stored (possibly stale) value, or with 0 if out of range.
- Key writes and key_clear never stall or flush words in flight.
- Reset mid-operation: in-flight words are discarded, keys are lost, and outputs return to reset values immediately (asynchronous).
- Arithmetic: pure bitwise XOR, DATA_W bits, no carry.

Test Plan:
1. Load 16 keys, key[i] = 48'h0000_0000_0100 * i + i. Send in_data=48'hFFFF_FFFF_FFFF, round=3, decrypt=0, out_ready=1.
   -> Two cycles later out_valid=1, out_data=FFFF_FFFF_FFFF ^ key[3], out_round=3, out_err=0.
2. Same load, round=3, decrypt=1 -> out_data = in_data ^ key[12].
3. Back-to-back stream of rounds 0..15, out_ready held 0 for 5 cycles.
   -> in_ready=0 after 2 accepts; no loss. Releasing out_ready delivers rounds 0..15 in order, one per cycle.
4. After key_clear, send round 5 with no reload -> out_err=1, out_data = in_data ^ old key[5].
   Then write key[5]=48'h123456789ABC and resend -> out_err=0, correct XOR.
5. Write key[7]=48'hAAAA_AAAA_AAAA in the same cycle a round-7 word is accepted -> that word uses the old key[7]; the next round-7 word uses AAAA_AAAA_AAAA.
6. Assert rst for 1 cycle with 2 words in flight -> out_valid=0 and in_ready=1 immediately. No stale word appears after release; a word sent post-reset gives out_err=1.
